// File: rtl/fpu_host_pkg.sv
// -----------------------------------------------------------------------------
// fpu_host_pkg
// Shared definitions for the FPU host driver: register window offsets,
// CTRL/STATUS bit positions, FSM state encoding, the captured command record
// and the CTRL word packer.
// -----------------------------------------------------------------------------
package fpu_host_pkg;

  // Register offsets from BASE_ADDR
  localparam logic [31:0] OFS_CTRL   = 32'h00;
  localparam logic [31:0] OFS_OPA    = 32'h04;
  localparam logic [31:0] OFS_OPB    = 32'h08;
  localparam logic [31:0] OFS_OPC    = 32'h0C;
  localparam logic [31:0] OFS_RESULT = 32'h10;
  localparam logic [31:0] OFS_STATUS = 32'h14;

  // CTRL word bit positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_INT_EN   = 1;
  localparam int CTRL_RST      = 2;
  localparam int CTRL_DOORBELL = 3;
  localparam int CTRL_FMT_LSB  = 4;
  localparam int CTRL_OP_LSB   = 6;
  localparam int CTRL_FUSED    = 8;
  localparam int CTRL_SIMD     = 9;
  localparam int CTRL_NOOP_LSB = 10;

  // STATUS word bit positions (bit0 is the doorbell echo, not used here)
  localparam int STAT_READY     = 1;
  localparam int STAT_FLAGS_LSB = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_WR_C,
    ST_WR_CTRL,
    ST_WAIT_IRQ,
    ST_RD_STAT,
    ST_CHK_STAT,
    ST_RD_RES,
    ST_CAP_RES,
    ST_WR_CLR,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic [1:0]  format;
    logic [1:0]  operation;
    logic        fused;
    logic        simd;
    logic [2:0]  simd_no_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_c;
  } cmd_t;

  // en is always set; the FPU soft-reset bit is never driven by this block.
  function automatic logic [31:0] pack_ctrl(input cmd_t c, input logic int_en,
                                            input logic doorbell);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN]                = 1'b1;
    w[CTRL_INT_EN]            = int_en;
    w[CTRL_RST]               = 1'b0;
    w[CTRL_DOORBELL]          = doorbell;
    w[CTRL_FMT_LSB +: 2]      = c.format;
    w[CTRL_OP_LSB +: 2]       = c.operation;
    w[CTRL_FUSED]             = c.fused;
    w[CTRL_SIMD]              = c.simd;
    w[CTRL_NOOP_LSB +: 3]     = c.simd_no_op;
    return w;
  endfunction

endpackage

// File: rtl/fpu_host_driver_if.sv
// -----------------------------------------------------------------------------
// fpu_host_driver_if
// Bundles the client command/response channel and the FPU software register
// port seen by the host driver.
//   master : driver view (accepts commands, issues register strobes)
//   slave  : environment view (client + FPU register port)
// -----------------------------------------------------------------------------
interface fpu_host_driver_if;
  // client command channel
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_format;
  logic [1:0]  cmd_operation;
  logic        cmd_fused;
  logic        cmd_simd;
  logic [2:0]  cmd_simd_no_op;
  logic [31:0] cmd_operand_a;
  logic [31:0] cmd_operand_b;
  logic [31:0] cmd_operand_c;
  // client response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_timeout;
  // FPU software register port
  logic [31:0] sw_address;
  logic        sw_read_en;
  logic        sw_write_en;
  logic [31:0] sw_datain;
  logic [31:0] sw_dataout;
  logic        fpu_interrupt;

  modport master (
    input  cmd_valid, cmd_format, cmd_operation, cmd_fused, cmd_simd,
           cmd_simd_no_op, cmd_operand_a, cmd_operand_b, cmd_operand_c,
           rsp_ready, sw_dataout, fpu_interrupt,
    output cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_timeout,
           sw_address, sw_read_en, sw_write_en, sw_datain
  );

  modport slave (
    output cmd_valid, cmd_format, cmd_operation, cmd_fused, cmd_simd,
           cmd_simd_no_op, cmd_operand_a, cmd_operand_b, cmd_operand_c,
           rsp_ready, sw_dataout, fpu_interrupt,
    input  cmd_ready, rsp_valid, rsp_result, rsp_flags, rsp_timeout,
           sw_address, sw_read_en, sw_write_en, sw_datain
  );
endinterface

// File: rtl/fpu_host_poll_timer.sv
// -----------------------------------------------------------------------------
// fpu_host_poll_timer
// Counts status polls / interrupt-wait cycles for one command.
//   clk, reset : clock, async active-high reset
//   i_clr      : restart count at zero (on command accept)
//   i_inc      : count one poll / wait cycle
//   o_tc       : count has reached LIMIT-1 (last allowed poll)
// -----------------------------------------------------------------------------
module fpu_host_poll_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/fpu_host_driver.sv
// -----------------------------------------------------------------------------
// fpu_host_driver
// Runs one FPU operation per accepted client command over the FPU software
// register port: operand writes, doorbell, completion wait (status polling or
// interrupt), result/flags read, doorbell clear, client response.
//   clk, reset : clock, async active-high reset
//   bus        : command/response channel and sw_* register port (master)
// Parameters: BASE_ADDR (register window), POLL_TIMEOUT (poll/wait limit),
//   USE_IRQ (wait for fpu_interrupt instead of polling).
// -----------------------------------------------------------------------------
module fpu_host_driver
  import fpu_host_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          POLL_TIMEOUT = 1024,
  parameter bit          USE_IRQ      = 1'b0
) (
  input logic              clk,
  input logic              reset,
  fpu_host_driver_if.master bus
);

  state_t      r_state;
  state_t      w_next;
  cmd_t        r_cmd;
  logic [31:0] r_result;
  logic [3:0]  r_flags;
  logic        r_timeout;

  logic        w_accept;
  logic        w_tmr_clr;
  logic        w_tmr_inc;
  logic        w_tc;
  logic        w_cap_flags;
  logic        w_cap_res;
  logic        w_set_timeout;
  logic        w_stat_ready;
  logic        w_unused_stat;

  assign w_stat_ready  = bus.sw_dataout[STAT_READY];
  assign w_unused_stat = ^{bus.sw_dataout[31:6], bus.sw_dataout[0]};

  fpu_host_poll_timer #(.LIMIT(POLL_TIMEOUT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_tmr_clr),
    .i_inc (w_tmr_inc),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cmd     <= '0;
      r_result  <= '0;
      r_flags   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cmd.format     <= bus.cmd_format;
        r_cmd.operation  <= bus.cmd_operation;
        r_cmd.fused      <= bus.cmd_fused;
        r_cmd.simd       <= bus.cmd_simd;
        r_cmd.simd_no_op <= bus.cmd_simd_no_op;
        r_cmd.op_a       <= bus.cmd_operand_a;
        r_cmd.op_b       <= bus.cmd_operand_b;
        r_cmd.op_c       <= bus.cmd_operand_c;
        r_result         <= '0;
        r_flags          <= '0;
        r_timeout        <= 1'b0;
      end
      if (w_cap_flags) r_flags <= bus.sw_dataout[STAT_FLAGS_LSB +: 4];
      if (w_cap_res)   r_result <= bus.sw_dataout;
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
        r_result  <= '0;
        r_flags   <= '0;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    w_accept        = 1'b0;
    w_tmr_clr       = 1'b0;
    w_tmr_inc       = 1'b0;
    w_cap_flags     = 1'b0;
    w_cap_res       = 1'b0;
    w_set_timeout   = 1'b0;
    bus.cmd_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.sw_address  = '0;
    bus.sw_read_en  = 1'b0;
    bus.sw_write_en = 1'b0;
    bus.sw_datain   = '0;

    unique case (r_state)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_accept  = 1'b1;
          w_tmr_clr = 1'b1;
          w_next    = ST_WR_A;
        end
      end
      ST_WR_A: begin
        bus.sw_write_en = 1'b1;
        bus.sw_address  = BASE_ADDR + OFS_OPA;
        bus.sw_datain   = r_cmd.op_a;
        w_next          = ST_WR_B;
      end
      ST_WR_B: begin
        bus.sw_write_en = 1'b1;
        bus.sw_address  = BASE_ADDR + OFS_OPB;
        bus.sw_datain   = r_cmd.op_b;
        w_next          = r_cmd.fused ? ST_WR_C : ST_WR_CTRL;
      end
      ST_WR_C: begin
        bus.sw_write_en = 1'b1;
        bus.sw_address  = BASE_ADDR + OFS_OPC;
        bus.sw_datain   = r_cmd.op_c;
        w_next          = ST_WR_CTRL;
      end
      ST_WR_CTRL: begin
        bus.sw_write_en = 1'b1;
        bus.sw_address  = BASE_ADDR + OFS_CTRL;
        bus.sw_datain   = pack_ctrl(r_cmd, USE_IRQ, 1'b1);
        w_next          = USE_IRQ ? ST_WAIT_IRQ : ST_RD_STAT;
      end
      ST_WAIT_IRQ: begin
        // Same counter as polling: one tick per cycle spent waiting.
        if (bus.fpu_interrupt) begin
          w_next = ST_RD_STAT;
        end else if (w_tc) begin
          w_set_timeout = 1'b1;
          w_next        = ST_WR_CLR;
        end else begin
          w_tmr_inc = 1'b1;
        end
      end
      ST_RD_STAT: begin
        bus.sw_read_en = 1'b1;
        bus.sw_address = BASE_ADDR + OFS_STATUS;
        w_next         = ST_CHK_STAT;
      end
      ST_CHK_STAT: begin
        // Read data for the STATUS strobe is on sw_dataout this cycle.
        if (USE_IRQ || w_stat_ready) begin
          w_cap_flags = 1'b1;
          w_next      = ST_RD_RES;
        end else if (w_tc) begin
          w_set_timeout = 1'b1;
          w_next        = ST_WR_CLR;
        end else begin
          w_tmr_inc = 1'b1;
          w_next    = ST_RD_STAT;
        end
      end
      ST_RD_RES: begin
        bus.sw_read_en = 1'b1;
        bus.sw_address = BASE_ADDR + OFS_RESULT;
        w_next         = ST_CAP_RES;
      end
      ST_CAP_RES: begin
        w_cap_res = 1'b1;
        w_next    = ST_WR_CLR;
      end
      ST_WR_CLR: begin
        bus.sw_write_en = 1'b1;
        bus.sw_address  = BASE_ADDR + OFS_CTRL;
        bus.sw_datain   = pack_ctrl(r_cmd, USE_IRQ, 1'b0);
        w_next          = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign bus.rsp_result  = r_result;
  assign bus.rsp_flags   = r_flags;
  assign bus.rsp_timeout = r_timeout;

endmodule

// File: tb/tb_fpu_host_driver.sv
module tb_fpu_host_driver;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpu_host_driver_if bus0 ();
  fpu_host_driver_if bus1 ();

  fpu_host_driver #(.BASE_ADDR(32'h0), .POLL_TIMEOUT(4), .USE_IRQ(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  fpu_host_driver #(.BASE_ADDR(32'h0), .POLL_TIMEOUT(1024), .USE_IRQ(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  int n_checks = 0;
  int n_errors = 0;
  int bus_viol = 0;

  // responder state and logs
  int          rdy_after0;
  logic [3:0]  flg0;
  logic [31:0] res0;
  int          stat_rd0;
  logic [31:0] wa0[$];
  logic [31:0] wd0[$];
  logic [31:0] ra0[$];
  logic [3:0]  flg1;
  logic [31:0] res1;
  int          stat_rd1;
  logic [31:0] ctrl1;

  always @(posedge clk) begin
    bus0.sw_dataout <= 32'hDEAD_BEEF;
    if (bus0.sw_read_en) begin
      ra0.push_back(bus0.sw_address);
      if (bus0.sw_address == 32'h14) begin
        stat_rd0 = stat_rd0 + 1;
        if (rdy_after0 != 0 && stat_rd0 >= rdy_after0)
          bus0.sw_dataout <= {26'd0, flg0, 2'b10};
        else
          bus0.sw_dataout <= {26'd0, 4'hA, 2'b00};
      end else if (bus0.sw_address == 32'h10) begin
        bus0.sw_dataout <= res0;
      end
    end
    if (bus0.sw_write_en) begin
      wa0.push_back(bus0.sw_address);
      wd0.push_back(bus0.sw_datain);
    end
  end

  always @(posedge clk) begin
    bus1.sw_dataout <= 32'hDEAD_BEEF;
    if (bus1.sw_read_en) begin
      if (bus1.sw_address == 32'h14) begin
        stat_rd1 = stat_rd1 + 1;
        bus1.sw_dataout <= {26'd0, flg1, 2'b00};
      end else if (bus1.sw_address == 32'h10) begin
        bus1.sw_dataout <= res1;
      end
    end
    if (bus1.sw_write_en && bus1.sw_address == 32'h0 && bus1.sw_datain[3])
      ctrl1 = bus1.sw_datain;
  end

  always @(negedge clk) begin
    if (bus0.sw_read_en && bus0.sw_write_en) bus_viol++;
    if (bus1.sw_read_en && bus1.sw_write_en) bus_viol++;
    if (!bus0.sw_read_en && !bus0.sw_write_en &&
        (bus0.sw_address != 0 || bus0.sw_datain != 0)) bus_viol++;
    if (!bus1.sw_read_en && !bus1.sw_write_en &&
        (bus1.sw_address != 0 || bus1.sw_datain != 0)) bus_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wa0.delete(); wd0.delete(); ra0.delete();
    stat_rd0 = 0;
  endtask

  // Called at a negedge in IDLE; returns number of cycles until rsp_valid.
  task automatic send0(input logic [1:0] fmt, input logic [1:0] op, input logic fused,
                       input logic simd, input logic [2:0] noop, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, output int lat);
    bus0.cmd_format = fmt; bus0.cmd_operation = op; bus0.cmd_fused = fused;
    bus0.cmd_simd = simd; bus0.cmd_simd_no_op = noop;
    bus0.cmd_operand_a = a; bus0.cmd_operand_b = b; bus0.cmd_operand_c = c;
    bus0.cmd_valid = 1'b1;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        // scramble inputs after acceptance; captured copy must be used
        bus0.cmd_valid = 1'b0;
        bus0.cmd_operand_a = 32'hFFFF_FFFF; bus0.cmd_operand_b = 32'hFFFF_FFFF;
        bus0.cmd_operand_c = 32'hFFFF_FFFF; bus0.cmd_fused = ~fused;
        bus0.cmd_format = ~fmt; bus0.cmd_operation = ~op;
      end
      if (bus0.rsp_valid) break;
    end
  endtask

  task automatic ack0();
    bus0.rsp_ready = 1'b1;
    #1;
    chk("resp_cmd_ready_low", {31'd0, bus0.cmd_ready}, 32'd0);
    @(negedge clk);
    bus0.rsp_ready = 1'b0;
    chk("post_resp_cmd_ready", {31'd0, bus0.cmd_ready}, 32'd1);
    chk("post_resp_rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    int nw;
    int nr;
    reset = 1'b1;
    bus0.cmd_valid = 0; bus0.cmd_format = 0; bus0.cmd_operation = 0; bus0.cmd_fused = 0;
    bus0.cmd_simd = 0; bus0.cmd_simd_no_op = 0; bus0.cmd_operand_a = 0;
    bus0.cmd_operand_b = 0; bus0.cmd_operand_c = 0; bus0.rsp_ready = 0;
    bus0.fpu_interrupt = 0;
    bus1.cmd_valid = 0; bus1.cmd_format = 0; bus1.cmd_operation = 0; bus1.cmd_fused = 0;
    bus1.cmd_simd = 0; bus1.cmd_simd_no_op = 0; bus1.cmd_operand_a = 0;
    bus1.cmd_operand_b = 0; bus1.cmd_operand_c = 0; bus1.rsp_ready = 0;
    bus1.fpu_interrupt = 0;
    rdy_after0 = 1; flg0 = 0; res0 = 0; stat_rd0 = 0;
    flg1 = 0; res1 = 0; stat_rd1 = 0; ctrl1 = 0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_cmd_ready", {31'd0, bus0.cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
    chk("rst_strobes", {30'd0, bus0.sw_read_en, bus0.sw_write_en}, 32'd0);
    chk("rst_address", bus0.sw_address, 32'd0);
    chk("rst_result", bus0.rsp_result, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: non-fused add, ready on first poll
    clear_logs(); rdy_after0 = 1; flg0 = 4'h0; res0 = 32'h4040_0000;
    send0(2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 32'h3F80_0000, 32'h4000_0000, 32'h0, lat);
    chk("t1_latency", lat, 32'd9);
    chk("t1_nwrites", wa0.size(), 32'd4);
    chk("t1_wr0_addr", wa0[0], 32'h04);
    chk("t1_wr0_data", wd0[0], 32'h3F80_0000);
    chk("t1_wr1_addr", wa0[1], 32'h08);
    chk("t1_wr1_data", wd0[1], 32'h4000_0000);
    chk("t1_ctrl_addr", wa0[2], 32'h00);
    chk("t1_ctrl_data", wd0[2], 32'h0000_0009);
    chk("t1_clr_addr", wa0[3], 32'h00);
    chk("t1_clr_data", wd0[3], 32'h0000_0001);
    chk("t1_nreads", ra0.size(), 32'd2);
    chk("t1_rd0_addr", ra0[0], 32'h14);
    chk("t1_rd1_addr", ra0[1], 32'h10);
    chk("t1_result", bus0.rsp_result, 32'h4040_0000);
    chk("t1_flags", {28'd0, bus0.rsp_flags}, 32'd0);
    chk("t1_timeout", {31'd0, bus0.rsp_timeout}, 32'd0);
    ack0();

    // 2: fused, SIMD fields
    clear_logs(); rdy_after0 = 1; flg0 = 4'h0; res0 = 32'h0BAD_F00D;
    send0(2'b01, 2'b11, 1'b1, 1'b1, 3'b101, 32'h1, 32'h2, 32'h1234_5678, lat);
    chk("t2_latency", lat, 32'd10);
    chk("t2_nwrites", wa0.size(), 32'd5);
    chk("t2_opc_addr", wa0[2], 32'h0C);
    chk("t2_opc_data", wd0[2], 32'h1234_5678);
    chk("t2_ctrl_data", wd0[3], 32'h0000_17D9);
    chk("t2_clr_data", wd0[4], 32'h0000_17D1);
    chk("t2_result", bus0.rsp_result, 32'h0BAD_F00D);
    ack0();

    // 3: ready on third poll, inexact
    clear_logs(); rdy_after0 = 3; flg0 = 4'b0001; res0 = 32'hC0A0_0000;
    send0(2'b00, 2'b01, 1'b0, 1'b0, 3'd0, 32'h5, 32'h6, 32'h0, lat);
    chk("t3_latency", lat, 32'd13);
    chk("t3_status_reads", stat_rd0, 32'd3);
    chk("t3_flags", {28'd0, bus0.rsp_flags}, 32'h1);
    chk("t3_result", bus0.rsp_result, 32'hC0A0_0000);
    ack0();

    // 4: never ready, POLL_TIMEOUT=4
    clear_logs(); rdy_after0 = 0; flg0 = 4'hF; res0 = 32'h7777_7777;
    send0(2'b00, 2'b00, 1'b0, 1'b0, 3'd0, 32'h7, 32'h8, 32'h0, lat);
    chk("t4_latency", lat, 32'd13);
    chk("t4_status_reads", stat_rd0, 32'd4);
    chk("t4_nreads", ra0.size(), 32'd4);
    chk("t4_last_wr_addr", wa0[wa0.size()-1], 32'h00);
    chk("t4_last_wr_data", wd0[wd0.size()-1], 32'h0000_0001);
    chk("t4_timeout", {31'd0, bus0.rsp_timeout}, 32'd1);
    chk("t4_result", bus0.rsp_result, 32'd0);
    chk("t4_flags", {28'd0, bus0.rsp_flags}, 32'd0);
    ack0();

    // 5: held response, then reset during WR_B of next command
    clear_logs(); rdy_after0 = 1; flg0 = 4'b1000; res0 = 32'h5555_AAAA;
    send0(2'b10, 2'b10, 1'b0, 1'b0, 3'd0, 32'h9, 32'hA, 32'h0, lat);
    chk("t5_latency", lat, 32'd9);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", {31'd0, bus0.rsp_valid}, 32'd1);
      chk("t5_hold_result", bus0.rsp_result, 32'h5555_AAAA);
      @(negedge clk);
    end
    chk("t5_flags", {28'd0, bus0.rsp_flags}, 32'h8);
    chk("t5_timeout_cleared", {31'd0, bus0.rsp_timeout}, 32'd0);
    ack0();
    bus0.cmd_operand_a = 32'h11; bus0.cmd_operand_b = 32'h22; bus0.cmd_fused = 0;
    bus0.cmd_valid = 1'b1;
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    @(negedge clk);
    chk("t5_wrb_strobe", {31'd0, bus0.sw_write_en}, 32'd1);
    chk("t5_wrb_addr", bus0.sw_address, 32'h08);
    reset = 1'b1;
    #1;
    chk("t5_rst_write_en", {31'd0, bus0.sw_write_en}, 32'd0);
    chk("t5_rst_address", bus0.sw_address, 32'd0);
    chk("t5_rst_datain", bus0.sw_datain, 32'd0);
    chk("t5_rst_cmd_ready", {31'd0, bus0.cmd_ready}, 32'd1);
    chk("t5_rst_rsp_result", bus0.rsp_result, 32'd0);
    chk("t5_rst_rsp_flags", {28'd0, bus0.rsp_flags}, 32'd0);
    nw = wa0.size(); nr = ra0.size();
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_no_writes_after_rst", wa0.size(), nw);
    chk("t5_no_reads_after_rst", ra0.size(), nr);
    chk("t5_idle_rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);

    // 6: IRQ mode, interrupt 7 cycles after doorbell write (T3 -> T10)
    stat_rd1 = 0; ctrl1 = 0; flg1 = 4'b0010; res1 = 32'h1111_2222;
    bus1.cmd_format = 0; bus1.cmd_operation = 0; bus1.cmd_fused = 0;
    bus1.cmd_operand_a = 32'h3; bus1.cmd_operand_b = 32'h4; bus1.cmd_valid = 1'b1;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) bus1.cmd_valid = 1'b0;
      if (lat == 10) begin
        chk("t6_no_early_poll", stat_rd1, 32'd0);
        bus1.fpu_interrupt = 1'b1;
      end
      if (bus1.rsp_valid) break;
    end
    chk("t6_latency", lat, 32'd16);
    chk("t6_status_reads", stat_rd1, 32'd1);
    chk("t6_ctrl_data", ctrl1, 32'h0000_000B);
    chk("t6_result", bus1.rsp_result, 32'h1111_2222);
    chk("t6_flags", {28'd0, bus1.rsp_flags}, 32'h2);
    chk("t6_timeout", {31'd0, bus1.rsp_timeout}, 32'd0);
    bus1.fpu_interrupt = 1'b0;
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
    chk("t6_idle", {31'd0, bus1.cmd_ready}, 32'd1);

    chk("bus_rules", bus_viol, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
